// File: rtl/drm_8x64_fifo_ctrl.sv
// drm_8x64_fifo_ctrl: FIFO controller over a 1-cycle-latency RAM with a 2-entry registered output queue
module drm_8x64_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic                  ram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_rst
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   ram_cnt, ram_nxt;
  logic                  inflight, push, pop, issue;
  logic [1:0]            outq_cnt, keep, outq_nxt;
  logic [DATA_WIDTH-1:0] q0, q1;
  assign s_ready        = ram_cnt != (ADDR_WIDTH+1)'(DEPTH);
  assign m_valid        = outq_cnt != 2'd0;
  assign m_data         = q0;
  assign push           = s_valid && s_ready;
  assign pop            = m_valid && m_ready;
  assign ram_wr_en      = push;
  assign ram_wr_addr    = wptr;
  assign ram_wr_data    = s_data;
  assign ram_wr_byte_en = 1'b1;
  assign ram_rd_addr    = rptr;
  assign ram_rst        = rst;
  // keep: queue entries that survive this cycle's pop; a read may only be issued if it will have a slot
  always_comb begin
    keep     = outq_cnt - {1'b0, pop};
    issue    = (ram_cnt != '0) && (({1'b0, keep} + {2'b0, inflight}) < 3'd2);
    ram_nxt  = ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    outq_nxt = keep + {1'b0, inflight};
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      outq_cnt <= 2'd0;
      count    <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_WIDTH'(1);
      if (issue) rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_nxt;
      inflight <= issue;
      outq_cnt <= outq_nxt;
      count    <= ram_nxt + (ADDR_WIDTH+1)'(issue) + (ADDR_WIDTH+1)'(outq_nxt);
    end
  end
  // returning read data lands behind whatever survives the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
    end else if (!flush) begin
      if (pop) q0 <= q1;
      if (inflight && keep == 2'd0) q0 <= ram_rd_data;
      if (inflight && keep == 2'd1) q1 <= ram_rd_data;
    end
  end
endmodule

// File: tb/tb_drm_8x64_fifo_ctrl.sv
// tb_drm_8x64_fifo_ctrl: directed and random checks of the FIFO controller against a queue-based model
module tb_drm_8x64_fifo_ctrl;
  logic       clk = 0, rst = 1, flush = 0, s_valid = 0, m_ready = 0;
  logic [7:0] s_data = 0, m_data, ram_wr_data, ram_rd_data;
  logic       s_ready, m_valid, ram_wr_en, ram_wr_byte_en, ram_rst;
  logic [6:0] count;
  logic [5:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] mem [64];
  logic [7:0] rd_q;
  logic [7:0] q [$];
  int m_ram = 0, m_outq = 0, m_inf = 0;
  int pass = 0, total = 0;

  drm_8x64_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_rst(ram_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_q <= mem[ram_rd_addr];
  end
  assign ram_rd_data = rd_q;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // occupancy model: RAM words, one read slot, output queue; data order from a plain queue
  always @(posedge clk) begin
    if (rst || flush) begin
      m_ram = 0; m_outq = 0; m_inf = 0; q.delete();
    end else begin
      automatic int pop = (m_outq > 0 && m_ready) ? 1 : 0;
      automatic int push = (s_valid && m_ram < 64) ? 1 : 0;
      automatic int iss = (m_ram > 0 && m_outq + m_inf - pop < 2) ? 1 : 0;
      m_outq = m_outq - pop + m_inf;
      m_inf = iss;
      m_ram = m_ram + push - iss;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    chk("s_ready", s_ready, m_ram < 64);
    chk("m_valid", m_valid, m_outq > 0);
    chk("count", count, q.size());
    if (m_valid && q.size() > 0) chk("m_data", m_data, q[0]);
  end

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    chk("wait_m_valid", m_valid, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("ram_wr_byte_en", ram_wr_byte_en, 1);
    chk("ram_rst", ram_rst, 0);
    // single word latency
    s_valid = 1; s_data = 8'hA5;
    @(negedge clk); s_valid = 0;
    @(negedge clk); chk("lat_e1_m_valid", m_valid, 0);
    @(negedge clk);
    chk("lat_m_valid", m_valid, 1);
    chk("lat_m_data", m_data, 8'hA5);
    chk("lat_count", count, 1);
    m_ready = 1; @(negedge clk); m_ready = 0;
    chk("pop_count", count, 0);
    // fill to 66, then drain in order
    for (int i = 0; i < 66; i++) begin s_valid = 1; s_data = 8'(i); @(negedge clk); end
    s_valid = 0;
    chk("fill_count", count, 66);
    chk("fill_s_ready", s_ready, 0);
    s_valid = 1; s_data = 8'hFF; @(negedge clk); s_valid = 0;
    chk("full_push_ignored", count, 66);
    chk("drain_head", m_data, 8'h00);
    m_ready = 1; repeat (70) @(negedge clk); m_ready = 0;
    chk("drain_count", count, 0);
    // streaming across pointer wrap
    s_valid = 1; m_ready = 1;
    for (int i = 0; i < 200; i++) begin s_data = 8'(i + 3); @(negedge clk); end
    chk("stream_count", count, 3);
    s_valid = 0; repeat (6) @(negedge clk); m_ready = 0;
    chk("stream_drained", count, 0);
    // flush while a read is in flight
    for (int i = 0; i < 3; i++) begin s_valid = 1; s_data = 8'(8'h10 + i); @(negedge clk); end
    s_valid = 0; flush = 1; @(negedge clk); flush = 0;
    chk("flush_count", count, 0);
    chk("flush_m_valid", m_valid, 0);
    s_valid = 1; s_data = 8'h5A; @(negedge clk); s_valid = 0;
    wait_valid();
    chk("flush_next_data", m_data, 8'h5A);
    m_ready = 1; @(negedge clk); m_ready = 0;
    // reset mid-stream
    for (int i = 0; i < 40; i++) begin s_valid = 1; s_data = 8'(8'h80 + i); @(negedge clk); end
    s_valid = 0; @(negedge clk);
    chk("pre_rst_count", count, 40);
    rst = 1; @(negedge clk); rst = 0;
    chk("rst2_count", count, 0);
    chk("rst2_m_valid", m_valid, 0);
    chk("rst2_s_ready", s_ready, 1);
    s_valid = 1; s_data = 8'h77; m_ready = 1; @(negedge clk); s_valid = 0;
    wait_valid();
    chk("rst2_data", m_data, 8'h77);
    @(negedge clk); m_ready = 0;
    // random traffic with rare flushes
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0) ^ (i[11] & ($urandom_range(0, 1) == 1));
      s_data = 8'($urandom);
      flush = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    s_valid = 0; flush = 0; m_ready = 1;
    repeat (80) @(negedge clk);
    chk("final_count", count, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
